// File: rtl/bc_bounce_back.sv
// Full-way bounce-back boundary stage for the D2Q9 lattice.
// Walks every node address from the boundary iterator, and for each perimeter
// node reads its nine distributions, swaps opposite directions and writes them back.
module bc_bounce_back #(
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 16,
    parameter int GRID_DIM      = GRID_W * GRID_H,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
    parameter int DATA_WIDTH    = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [ADDRESS_WIDTH-1:0]   addr_in,
    output logic                       addr_ready,
    output logic [ADDRESS_WIDTH-1:0]   mem_addr,
    output logic                       mem_rd_en,
    input  logic [9*DATA_WIDTH-1:0]    mem_rdata,
    output logic                       mem_wr_en,
    output logic [9*DATA_WIDTH-1:0]    mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic [ADDRESS_WIDTH:0]     bc_count
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = ADDRESS_WIDTH - XW;

    // Opposite direction for each lane: 0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE.
    localparam int OPP [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SWAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [ADDRESS_WIDTH:0]    seen_cnt;
    logic [ADDRESS_WIDTH:0]    seen_inc;
    logic [ADDRESS_WIDTH-1:0]  node_addr;
    logic [9*DATA_WIDTH-1:0]   swap_q;
    logic [9*DATA_WIDTH-1:0]   swapped;
    logic [XW-1:0]             pos_x;
    logic [YW-1:0]             pos_y;
    logic                      is_boundary;

    assign pos_x    = addr_in[XW-1:0];
    assign pos_y    = addr_in[ADDRESS_WIDTH-1:XW];
    assign seen_inc = seen_cnt + 1'b1;

    // Classify the presented address as perimeter or interior.
    always_comb begin
        is_boundary = (pos_x == '0) || (pos_x == XW'(GRID_W - 1)) ||
                      (pos_y == '0) || (pos_y == YW'(GRID_H - 1));
    end

    // Exchange each direction with its opposite in the freshly read node word.
    always_comb begin
        swapped = '0;
        for (int k = 0; k < 9; k++) begin
            swapped[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata[OPP[k]*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state and strobe decode; strobes are pure functions of state so reset clears them at once.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        state_nxt  = state;
        addr_ready = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        done       = 1'b0;
        mem_addr   = addr_in;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                addr_ready = 1'b1;
                if (is_boundary) begin
                    mem_rd_en = 1'b1;
                    state_nxt = S_SWAP;
                end else if (seen_inc == (ADDRESS_WIDTH+1)'(GRID_DIM)) begin
                    state_nxt = S_DONE;
                end
            end
            S_SWAP: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = node_addr;
                state_nxt = (seen_cnt == (ADDRESS_WIDTH+1)'(GRID_DIM)) ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign mem_wdata = swap_q;

    // State register plus sweep counters and the latched node address / swapped data.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state     <= S_IDLE;
            seen_cnt  <= '0;
            bc_count  <= '0;
            // NOTE: the datapath holding registers are plain flops, not memory, so clearing them costs nothing and keeps simulation X-free.
            node_addr <= '0;
            swap_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seen_cnt <= '0;
                        bc_count <= '0;
                    end
                end
                S_SCAN: begin
                    seen_cnt <= seen_inc;
                    if (is_boundary) node_addr <= addr_in;
                end
                S_SWAP:  swap_q   <= swapped;
                S_WRITE: bc_count <= bc_count + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bc_bounce_back.sv
// Self-checking bench: two instances (16x16 and 4x4) with iterator and node-memory models.
module tb_bc_bounce_back;

    localparam int DW = 16;
    localparam int WW = 9 * DW;

    logic Clk = 1'b0;
    logic Reset;
    logic a_start, b_start, preload;

    // 16x16 instance signals
    logic [7:0]    a_it, a_maddr;
    logic          a_ready, a_rd, a_wr, a_busy, a_done;
    logic [WW-1:0] a_rdata, a_wdata;
    logic [8:0]    a_bc;
    logic [WW-1:0] a_mem [256];

    // 4x4 instance signals
    logic [3:0]    b_it, b_maddr;
    logic          b_ready, b_rd, b_wr, b_busy, b_done;
    logic [WW-1:0] b_rdata, b_wdata;
    logic [4:0]    b_bc;
    logic [WW-1:0] b_mem [16];

    int opp [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

    typedef struct {
        int            addr;
        logic [WW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit which;
        int node;
        bit bnd;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    bit sel   = 1'b0;

    always #10 Clk = ~Clk;

    bc_bounce_back #(.GRID_W(16), .GRID_H(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .start(a_start), .addr_in(a_it), .addr_ready(a_ready),
        .mem_addr(a_maddr), .mem_rd_en(a_rd), .mem_rdata(a_rdata), .mem_wr_en(a_wr),
        .mem_wdata(a_wdata), .busy(a_busy), .done(a_done), .bc_count(a_bc)
    );

    bc_bounce_back #(.GRID_W(4), .GRID_H(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .start(b_start), .addr_in(b_it), .addr_ready(b_ready),
        .mem_addr(b_maddr), .mem_rd_en(b_rd), .mem_rdata(b_rdata), .mem_wr_en(b_wr),
        .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .bc_count(b_bc)
    );

    function automatic logic [WW-1:0] pattern(input int node);
        logic [WW-1:0] v;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = 16'(node * 16 + k + 1);
        return v;
    endfunction

    function automatic logic [WW-1:0] swap9(input logic [WW-1:0] v);
        logic [WW-1:0] r;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = v[opp[k]*DW +: DW];
        return r;
    endfunction

    function automatic bit boundary(input int addr, input int gw, input int gh);
        int x, y;
        x = addr % gw;
        y = addr / gw;
        return (x == 0) || (x == gw - 1) || (y == 0) || (y == gh - 1);
    endfunction

    // Iterator models and 1-cycle-latency node memories.
    always @(posedge Clk) begin
        if (Reset) begin
            a_it <= '0;
            b_it <= '0;
        end else begin
            if (a_ready) a_it <= a_it + 1'b1;
            if (b_ready) b_it <= b_it + 1'b1;
        end
        if (preload) begin
            for (int i = 0; i < 256; i++) a_mem[i] <= pattern(i);
            for (int i = 0; i < 16; i++)  b_mem[i] <= pattern(i);
        end else begin
            if (a_rd) a_rdata <= a_mem[a_maddr];
            if (a_wr) a_mem[a_maddr] <= a_wdata;
            if (b_rd) b_rdata <= b_mem[b_maddr];
            if (b_wr) b_mem[b_maddr] <= b_wdata;
        end
    end

    // Muxed view of whichever instance is under test.
    logic          s_ready, s_rd, s_wr, s_busy, s_done;
    logic [7:0]    s_maddr, s_addr_in;
    logic [WW-1:0] s_wdata;
    logic [8:0]    s_bc;
    assign s_ready   = sel ? b_ready : a_ready;
    assign s_rd      = sel ? b_rd    : a_rd;
    assign s_wr      = sel ? b_wr    : a_wr;
    assign s_busy    = sel ? b_busy  : a_busy;
    assign s_done    = sel ? b_done  : a_done;
    assign s_maddr   = sel ? {4'b0, b_maddr} : a_maddr;
    assign s_addr_in = sel ? {4'b0, b_it}    : a_it;
    assign s_wdata   = sel ? b_wdata : a_wdata;
    assign s_bc      = sel ? {4'b0, b_bc} : a_bc;

    function automatic logic [WW-1:0] mem_get(input bit which, input int addr);
        return which ? b_mem[addr % 16] : a_mem[addr % 256];
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_preload();
        @(negedge Clk);
        preload = 1'b1;
        @(negedge Clk);
        preload = 1'b0;
    endtask

    task automatic set_start(input bit v);
        if (sel) b_start = v; else a_start = v;
    endtask

    // One full sweep with scoreboard on writes; optional stray start during SCAN.
    task automatic run_sweep(input bit which, input int exp_bnd, input int exp_done, input bit stray);
        int gw, gh, n, n_rd, n_wr, n_ar, n_done, done_at;
        exp_t e;
        gw = which ? 4 : 16;
        gh = gw;
        sel = which;
        sb_q.delete();
        n = 0; n_rd = 0; n_wr = 0; n_ar = 0; n_done = 0; done_at = 0;
        @(negedge Clk);
        set_start(1'b1);
        while (n < exp_done + 20) begin
            @(negedge Clk);
            n++;
            set_start(stray && (n == 10));
            if (n == 1) check("busy_during_sweep", 144'(s_busy), 144'(1));
            if (s_ready) begin
                n_ar++;
                check("classify", 144'(s_rd), 144'(boundary(int'(s_addr_in), gw, gh)));
            end
            if (s_rd) begin
                n_rd++;
                check("rd_addr", 144'(s_maddr), 144'(s_addr_in));
                e.addr = int'(s_maddr);
                e.data = swap9(mem_get(which, int'(s_maddr)));
                sb_q.push_back(e);
            end
            if (s_wr) begin
                n_wr++;
                if (sb_q.size() == 0) begin
                    check("wr_without_rd", 144'(1), 144'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", 144'(s_maddr), 144'(e.addr));
                    check("wr_data", s_wdata, e.data);
                end
            end
            if (s_done) begin
                n_done++;
                if (done_at == 0) done_at = n;
            end
            if (done_at != 0 && n == done_at + 1) check("busy_after_done", 144'(s_busy), 144'(0));
            if (done_at != 0 && n >= done_at + 3) break;
        end
        set_start(1'b0);
        check("done_latency", 144'(done_at), 144'(exp_done));
        check("done_pulses", 144'(n_done), 144'(1));
        check("rd_count", 144'(n_rd), 144'(exp_bnd));
        check("wr_count", 144'(n_wr), 144'(exp_bnd));
        check("ready_count", 144'(n_ar), 144'(gw * gh));
        check("bc_count", 144'(s_bc), 144'(exp_bnd));
        check("sb_empty", 144'(sb_q.size()), 144'(0));
    endtask

    initial begin
        vec_t tbl [13];
        logic [WW-1:0] node0_exp;
        int lanes0 [9] = '{1, 4, 5, 2, 3, 8, 9, 6, 7};
        int guard;

        tbl = '{
            '{1'b0, 0, 1'b1},   '{1'b0, 15, 1'b1},  '{1'b0, 16, 1'b1},  '{1'b0, 17, 1'b0},
            '{1'b0, 31, 1'b1},  '{1'b0, 34, 1'b0},  '{1'b0, 136, 1'b0}, '{1'b0, 240, 1'b1},
            '{1'b0, 255, 1'b1}, '{1'b1, 5, 1'b0},   '{1'b1, 6, 1'b0},   '{1'b1, 9, 1'b0},
            '{1'b1, 12, 1'b1}
        };

        Reset = 1'b1; a_start = 1'b0; b_start = 1'b0; preload = 1'b0;

        // Reset held with start low: everything quiet, iterator parked at 0.
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("rst_ready", 144'(a_ready), 144'(0));
            check("rst_strobes", 144'({a_rd, a_wr, a_done, a_busy}), 144'(0));
            check("rst_bc", 144'(a_bc), 144'(0));
            check("rst_iter", 144'(a_it), 144'(0));
        end
        check("rst_b_outputs", 144'({b_ready, b_rd, b_wr, b_done, b_busy, b_bc}), 144'(0));
        Reset = 1'b0;

        // Full 16x16 sweep with a stray start in SCAN, then the 4x4 sweep.
        do_preload();
        run_sweep(1'b0, 60, 377, 1'b1);
        run_sweep(1'b1, 12, 41, 1'b0);

        // Final node contents: boundary nodes swapped once, interior untouched.
        for (int i = 0; i < 13; i++) begin
            check($sformatf("node_%0d_%0d", tbl[i].which, tbl[i].node), mem_get(tbl[i].which, tbl[i].node),
                  tbl[i].bnd ? swap9(pattern(tbl[i].node)) : pattern(tbl[i].node));
        end
        for (int k = 0; k < 9; k++) node0_exp[k*DW +: DW] = 16'(lanes0[k]);
        check("node0_lanes", a_mem[0], node0_exp);

        // Reset while node 16 sits in SWAP: the pending write must never happen.
        sel = 1'b0;
        do_preload();
        @(negedge Clk);
        a_start = 1'b1;
        guard = 0;
        do begin
            @(negedge Clk);
            a_start = 1'b0;
            guard++;
        end while (!(a_rd && a_maddr == 8'd16) && guard < 200);
        check("reach_node16", 144'(guard < 200), 144'(1));
        @(negedge Clk);
        check("swap_state_quiet", 144'({a_ready, a_rd, a_wr, a_busy}), 144'(4'b0001));
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_mid_wr", 144'(a_wr), 144'(0));
        check("rst_mid_busy", 144'(a_busy), 144'(0));
        check("rst_mid_bc", 144'(a_bc), 144'(0));
        check("rst_mid_other", 144'({a_ready, a_rd, a_done}), 144'(0));
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("node16_unchanged", a_mem[16], pattern(16));
        check("node15_swapped", a_mem[15], swap9(pattern(15)));
        check("idle_after_rst", 144'(a_busy), 144'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bc_bounce_back.md
# bc_bounce_back

Full-way bounce-back boundary stage for the D2Q9 lattice. It consumes the node-address stream of the boundary address iterator and throttles it through that iterator's `Enable`. It classifies each address as interior or perimeter. For perimeter nodes it does a read-swap-write of the node's nine distributions in node memory, exchanging opposite directions. One sweep covers the whole grid, runs after each streaming pass, and ends with a `done` pulse to the lattice sequencer.

## Interface
- `GRID_W`, 16, grid width in nodes (power of two)
- `GRID_H`, 16, grid height in nodes
- `GRID_DIM`, `GRID_W*GRID_H`, total node count
- `ADDRESS_WIDTH`, `$clog2(GRID_DIM)`, node address width
- `DATA_WIDTH`, 16, width of one distribution value
- `Clk`  in  1  system clock (50 MHz)
- `Reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `addr_in`  in  `ADDRESS_WIDTH`  current node address from the iterator
- `addr_ready`  out  1  drives iterator `Enable`; the iterator advances on each edge where this is 1
- `mem_addr`  out  `ADDRESS_WIDTH`  node memory address
- `mem_rd_en`  out  1  node memory read strobe
- `mem_rdata`  in  `9*DATA_WIDTH`  read data; valid the cycle after `mem_rd_en`
- `mem_wr_en`  out  1  node memory write strobe
- `mem_wdata`  out  `9*DATA_WIDTH`  write data
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle sweep-complete pulse
- `bc_count`  out  `ADDRESS_WIDTH+1`  perimeter nodes processed in the last or current sweep

## Operation
- Lane packing: direction k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`, k=0..8.
  - Numbering: 0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE.
- Swap map: wdata lane k = rdata lane opp(k), with opp = {0,3,4,1,2,7,8,5,6}.
- Classification is combinational on `addr_in`:
  - x = `addr_in mod GRID_W` (low bits), y = `addr_in / GRID_W` (high bits).
  - The node is a boundary node when x==0, x==GRID_W-1, y==0 or y==GRID_H-1.
- Internal registers:
  - state
  - `seen_cnt` (`ADDRESS_WIDTH+1` bits): addresses consumed
  - `node_addr`: latched boundary address
  - `swap_q`: swapped data
  - `bc_count`
- FSM states:
  - IDLE: `addr_ready`=0. On `start`, clear `seen_cnt` and `bc_count`, go to SCAN.
  - SCAN:
    - `addr_ready`=1, `seen_cnt`+1.
    - Interior address: no memory access. Go to DONE if `seen_cnt`+1==GRID_DIM, else stay in SCAN.
    - Boundary address: `mem_rd_en`=1, `mem_addr`=`addr_in`, latch `node_addr`, go to SWAP.
  - SWAP: `addr_ready`=0. Register `swap_q` = swap(`mem_rdata`), go to WRITE.
  - WRITE:
    - `addr_ready`=0, `mem_wr_en`=1, `mem_addr`=`node_addr`, `mem_wdata`=`swap_q`, `bc_count`+1.
    - Go to DONE if `seen_cnt`==GRID_DIM, else back to SCAN.
  - DONE: `done`=1, go to IDLE.
- `busy` = (state != IDLE).
- `bc_count` holds its value after DONE until the next `start`.
- Outside the cases above, `mem_rd_en`, `mem_wr_en` and `addr_ready` are 0. `mem_addr` and `mem_wdata` are don't-care when no strobe is active.
- `start` outside IDLE is ignored.
- The sequencer issues `start` only with the iterator at address 0. The block does not check this.

## Timing
- Reset values: state IDLE; `addr_ready`, `mem_rd_en`, `mem_wr_en`, `busy`, `done` = 0; `bc_count`, `seen_cnt` = 0.
- Reset mid-sweep wins over every transition. The cycle after Reset, no strobe is active, including a pending WRITE.
- Cost per node: interior 1 cycle (SCAN); boundary 3 cycles (SCAN, SWAP, WRITE).
- Sweep cycles (SCAN+SWAP+WRITE) = GRID_DIM + 2×perimeter nodes, where perimeter = 2·GRID_W + 2·GRID_H − 4.
  - 16×16: 256 + 120 = 376 cycles.
  - DONE is the next cycle, so `done` is high 377 cycles after the edge that sampled `start`.
- Exactly one `addr_ready` cycle per address, so exactly GRID_DIM across a sweep. The iterator wraps to 0 at the end.
- Read-to-write latency per boundary node: 2 cycles (`mem_rd_en` at t, `mem_wr_en` at t+2).
- Memory read latency is exactly 1 cycle, no backpressure.

## Test plan
- Reset with `start`=0 for 5 cycles -> all outputs 0; `addr_ready` stays 0; iterator model holds at 0.
- Full 16×16 sweep, iterator model advancing on `addr_ready` -> 60 `mem_rd_en` and 60 `mem_wr_en`, 256 `addr_ready` cycles, `done` 377 cycles after start, `bc_count`=60, `busy` low the cycle after `done`.
- Node 0 preloaded with lanes k=0..8 = k+1 -> node 0 written with lanes {1,4,5,2,3,8,9,6,7}; interior node 17 never read or written.
- Reset asserted in the SWAP state of node 16 -> no `mem_wr_en` the next cycle; `busy`=0; `bc_count`=0; node 16 unchanged.
- `start` pulsed during SCAN -> ignored; the sweep completes with exactly one `done`.
- `GRID_W`=4, `GRID_H`=4 -> 12 boundary nodes, `done` 41 cycles after start (40 sweep cycles), interior nodes 5, 6, 9, 10 untouched.
